// File: rtl/wwd_output_logic.sv
// wwd_output_logic
// Receiving end of the CPU WWD output path. Buffers WWD words in a small FIFO,
// shows the oldest word as four hex digits on a multiplexed active-low
// 7-segment display (operator pops with a button), and mirrors the PC low
// byte onto the board LEDs.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wwd_valid/ready   word handshake (wwd_ready is combinational from count)
//   wwd_data[15:0]    WWD word
//   next_btn          debounced level button; a rising edge pops one entry
//   pc_below8bit[7:0] PC low byte, registered onto led_out[7:0]
//   seg[6:0]          segments {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]           digit anodes, active-low one-hot, registered
//   empty_led         high when the FIFO is empty, registered
//
// Optional feature macro: WWD_DROP_OLDEST_EN
//   When defined, wwd_ready is tied high and a push into a full FIFO
//   overwrites the oldest entry instead of backpressuring.

module wwd_output_logic #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wwd_valid,
    input  logic [15:0] wwd_data,
    output logic        wwd_ready,
    input  logic        next_btn,
    input  logic [7:0]  pc_below8bit,
    output logic [7:0]  led_out,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        empty_led
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [6:0]        SEG_BLANK = 7'h7F;

    // Active-low gfedcba hex decode
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [15:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              btn_q, btn_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        led_q, led_d;
    logic              empty_led_q, empty_led_d;

    logic        full, empty, pop_evt, push, do_pop, overwrite, mem_we;
    logic [15:0] head;
    logic [3:0]  nibble;

    // Ready depends only on the registered count, never on the button
`ifdef WWD_DROP_OLDEST_EN
    assign wwd_ready = 1'b1;
`else
    assign wwd_ready = (count_q != FULL_CNT);
`endif

    // FIFO control, scan and display next-state
    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        pop_evt   = next_btn & ~btn_q;
        push      = wwd_valid & wwd_ready;
`ifdef WWD_DROP_OLDEST_EN
        // Overwrite on full wins over a coincident pop edge
        overwrite = push & full;
`else
        overwrite = 1'b0;
`endif
        do_pop    = pop_evt & ~empty & ~overwrite;
        mem_we    = push & ~reset;

        wr_ptr_d  = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = (do_pop | overwrite) ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push & ~overwrite, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        btn_d = next_btn;
        led_d = pc_below8bit;
        empty_led_d = (count_d == '0);

        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end

        head = mem_q[rd_ptr_q];
        case (idx_q)
            2'd0:    nibble = head[3:0];
            2'd1:    nibble = head[7:4];
            2'd2:    nibble = head[11:8];
            default: nibble = head[15:12];
        endcase

        an_d  = ~(4'b0001 << idx_q);
        seg_d = empty ? SEG_BLANK : hex_to_seg(nibble);
    end

    // Storage array; contents are don't-care while not counted
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wwd_data;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            btn_q       <= 1'b0;
            scan_q      <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'hF;
            led_q       <= 8'h00;
            empty_led_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            btn_q       <= btn_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            led_q       <= led_d;
            empty_led_q <= empty_led_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign led_out   = led_q;
    assign empty_led = empty_led_q;

endmodule

// File: tb/tb_wwd_output_logic.sv
// Directed bench for wwd_output_logic: hand sequences for reset, scan timing
// and reset mid-operation, plus a table of per-cycle FIFO operations with
// hand-computed ready/empty/LED/head expectations.
module tb_wwd_output_logic;

    localparam int unsigned SCAN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wwd_valid;
    logic [15:0] wwd_data;
    logic        wwd_ready;
    logic        next_btn;
    logic [7:0]  pc_below8bit;
    logic [7:0]  led_out;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        empty_led;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wwd_output_logic #(.DEPTH(4), .ADDR_W(2), .SCAN_DIV(SCAN)) dut (
        .clk          (clk),
        .reset        (reset),
        .wwd_valid    (wwd_valid),
        .wwd_data     (wwd_data),
        .wwd_ready    (wwd_ready),
        .next_btn     (next_btn),
        .pc_below8bit (pc_below8bit),
        .led_out      (led_out),
        .seg          (seg),
        .an           (an),
        .empty_led    (empty_led)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        b;
        logic        exp_ready;
        logic        exp_empty;
        logic        chk;
        logic [15:0] exp_head;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic b,
                                input logic r, input logic e, input logic c,
                                input logic [15:0] h);
        vec_t x;
        x.v = v; x.d = d; x.b = b; x.exp_ready = r; x.exp_empty = e;
        x.chk = c; x.exp_head = h;
        return x;
    endfunction

    function automatic logic [6:0] hseg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle the inputs and collect the segment pattern of every digit slot
    task automatic read_disp(input string name, input logic exp_empty, input logic [15:0] h);
        logic [6:0]  got [4];
        logic [3:0]  seen;
        logic [27:0] act_v;
        logic [27:0] exp_v;
        wwd_valid = 1'b0;
        next_btn  = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 4; i++) got[i] = 7'h00;
        tick();
        tick();
        for (int c = 0; c < int'(4 * SCAN); c++) begin
            tick();
            case (an)
                4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
                4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
                4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check({name, "_an"}, 32'(seen), 32'hF);
        act_v = {got[3], got[2], got[1], got[0]};
        exp_v = exp_empty ? {4{7'h7F}}
                          : {hseg(h[15:12]), hseg(h[11:8]), hseg(h[7:4]), hseg(h[3:0])};
        check(name, 32'(act_v), 32'(exp_v));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wwd_valid = 1'b0;
        next_btn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         dig;
        one = 4'b0001;
        wwd_data = 16'h0000;
        pc_below8bit = 8'h3C;

        // Reset state
        do_reset();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_led", 32'(led_out), 32'h00);
        check("rst_empty", 32'(empty_led), 32'h1);
        check("rst_ready", 32'(wwd_ready), 32'h1);

        // One word 0x0001, full scan with exact registered timing
        wwd_valid = 1'b1;
        wwd_data  = 16'h0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                wwd_valid = 1'b0;
                check("one_led", 32'(led_out), 32'h3C);
                check("one_empty", 32'(empty_led), 32'h0);
            end
            dig     = (k - 1) / 4;
            exp_an  = ~(one << dig);
            exp_seg = (k == 1) ? 7'h7F : ((dig == 0) ? 7'h79 : 7'h40);
            check($sformatf("one_an_k%0d", k), 32'(an), 32'(exp_an));
            check($sformatf("one_seg_k%0d", k), 32'(seg), 32'(exp_seg));
        end

        do_reset();

`ifdef WWD_DROP_OLDEST_EN
        tbl.push_back(mk(1, 16'h0001, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0002, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0003, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0004, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h0005, 0, 1, 0, 1, 16'h0002));
        tbl.push_back(mk(1, 16'h0006, 1, 1, 0, 1, 16'h0003));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h0004));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h0005));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h0006));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 16'h0000));
`else
        tbl.push_back(mk(1, 16'h1234, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h5678, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h9ABC, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'hDEF0, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h5678));
        tbl.push_back(mk(1, 16'hFFFF, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h9ABC));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'hAAAA, 1, 1, 0, 1, 16'hFFFF));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'hAAAA));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 16'h0));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 16'h0));
        tbl.push_back(mk(1, 16'h0F0F, 1, 1, 0, 1, 16'h0F0F));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 16'h0));
        tbl.push_back(mk(1, 16'h1111, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h2222, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h3333, 0, 1, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h4444, 0, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 16'h5555, 1, 1, 0, 1, 16'h2222));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h3333));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h4444));
        tbl.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 16'h0));
`endif

        foreach (tbl[i]) begin
            wwd_valid    = tbl[i].v;
            wwd_data     = tbl[i].d;
            next_btn     = tbl[i].b;
            pc_below8bit = 8'(8'h40 + i);
            tick();
            check($sformatf("row%0d_ready", i), 32'(wwd_ready), 32'(tbl[i].exp_ready));
            check($sformatf("row%0d_empty", i), 32'(empty_led), 32'(tbl[i].exp_empty));
            check($sformatf("row%0d_led", i), 32'(led_out), 32'(8'(8'h40 + i)));
            if (tbl[i].chk)
                read_disp($sformatf("row%0d_disp", i), tbl[i].exp_empty, tbl[i].exp_head);
        end
        wwd_valid = 1'b0;
        next_btn  = 1'b0;

        // Reset mid-scan with three entries buffered
        wwd_valid = 1'b1;
        wwd_data = 16'hC0DE; tick();
        wwd_data = 16'hBEEF; tick();
        wwd_data = 16'h1357; tick();
        wwd_valid = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check("mid_empty_pre", 32'(empty_led), 32'h0);
        pc_below8bit = 8'h15;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg), 32'h7F);
        check("mid_rst_led", 32'(led_out), 32'h00);
        check("mid_rst_empty", 32'(empty_led), 32'h1);
        tick();
        check("mid_led_follow", 32'(led_out), 32'h15);
        check("mid_an_idx0", 32'(an), 32'hE);
        check("mid_ready", 32'(wwd_ready), 32'h1);
        read_disp("mid_disp", 1'b1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
